controller: RTL and testbench

Control unit of the 19-bit single-issue processor. Decodes the current instruction word from instruction memory into datapath controls:
- register-file read and write-back selection;
- ALU and shifter function;
- flag-update enables;
- data-memory strobes;
- PC advance.

A small state machine stretches loads to two cycles. Every other instruction completes in one cycle.

---
 rtl/controller_pkg.sv | 105 ++++++++++
 rtl/controller_decode.sv | 90 +++++++++
 rtl/controller.sv | 93 +++++++++
 tb/tb_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// -----------------------------------------------------------------------------
// controller_pkg
// Shared definitions for the 19-bit processor control unit:
//   - instruction class / group field codes
//   - ALU and shifter function codes
//   - write-back source encodings
//   - controller state enum
//   - control-vector struct plus small helper functions
// -----------------------------------------------------------------------------
package controller_pkg;

  // Instruction class in [18:17] (ALU classes only need two bits)
  localparam logic [1:0] CLASS_ALU_REG = 2'b00;
  localparam logic [1:0] CLASS_ALU_IMM = 2'b01;

  // Instruction group in [18:16] for the non-ALU half of the opcode space
  localparam logic [2:0] GRP_MEM   = 3'b100;
  localparam logic [2:0] GRP_NOP_A = 3'b101;
  localparam logic [2:0] GRP_SHIFT = 3'b110;
  localparam logic [2:0] GRP_NOP_B = 3'b111;

  // Memory sub-op in [15:14]; 10 and 11 are NOPs
  localparam logic [1:0] MEM_LDM = 2'b00;
  localparam logic [1:0] MEM_STM = 2'b01;

  // ALU function codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_ADC  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_SBC  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_MASK = 3'b111;

  // Shifter function codes
  localparam logic [1:0] SH_SHL = 2'b00;
  localparam logic [1:0] SH_SHR = 2'b01;
  localparam logic [1:0] SH_ROL = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Write-back source encodings
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_SHIFT = 2'b01;
  localparam logic [1:0] WB_MEM   = 2'b10;
  localparam logic [1:0] WB_NONE  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_EXEC = 2'b01,
    ST_LD2  = 2'b10
  } state_t;

  // Complete set of datapath controls driven by the controller
  typedef struct packed {
    logic [1:0] select_to_write;
    logic       select_r2;
    logic       select_alu_arg;
    logic [2:0] alu_function;
    logic [1:0] sh_ro_function;
    logic       stm;
    logic       ldm;
    logic       enable_pc;
    logic       enable_zero;
    logic       enable_carry;
    logic       mem_read;
  } ctrl_t;

  // Arithmetic ops (ADD/ADC/SUB/SBC, codes 000-011) are the only ALU ops
  // that produce a meaningful carry.
  function automatic logic alu_sets_carry(input logic [2:0] fn);
    return (fn[2] == 1'b0);
  endfunction

  // All-zero control vector (RST state; note write-back source reads as ALU)
  function automatic ctrl_t ctrl_zero();
    ctrl_t c;
    c = '0;
    return c;
  endfunction

  // Decode baseline: nothing happens, no register is written
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c = '0;
    c.select_to_write = WB_NONE;
    return c;
  endfunction

  // Second cycle of a load: write memory data back, keep the address path
  // (Rs + imm8) stable, and advance the PC.
  function automatic ctrl_t ctrl_load2();
    ctrl_t c;
    c = ctrl_idle();
    c.select_to_write = WB_MEM;
    c.select_alu_arg  = 1'b1;
    c.alu_function    = ALU_ADD;
    c.mem_read        = 1'b1;
    c.ldm             = 1'b1;
    c.enable_pc       = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/controller_decode.sv
// -----------------------------------------------------------------------------
// controller_decode
// Purely combinational instruction decoder producing the EXEC-state control
// vector. Only the opcode bits [18:14] of the instruction influence control.
// Ports:
//   opcode  in  5  instruction bits [18:14]
//   ctrl    out    EXEC-state control vector
//   is_load out 1  instruction is an LDM (needs a second cycle)
// -----------------------------------------------------------------------------
module controller_decode
  import controller_pkg::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl,
  output logic       is_load
);

  logic [1:0] op_class;
  logic       op_grp_bit;
  logic [2:0] op_fn;
  logic [1:0] op_sub;

  assign op_class   = opcode[4:3];
  assign op_grp_bit = opcode[2];
  assign op_fn      = opcode[2:0];
  assign op_sub     = opcode[1:0];

  // Class/field decode into the control vector
  always_comb begin
    ctrl    = ctrl_idle();
    is_load = 1'b0;
    case (op_class)
      CLASS_ALU_REG, CLASS_ALU_IMM: begin
        ctrl.select_to_write = WB_ALU;
        ctrl.select_r2       = 1'b0;
        ctrl.select_alu_arg  = (op_class == CLASS_ALU_IMM);
        ctrl.alu_function    = op_fn;
        ctrl.enable_zero     = 1'b1;
        ctrl.enable_carry    = alu_sets_carry(op_fn);
        ctrl.enable_pc       = 1'b1;
      end
      2'b10: begin
        // group 100 is memory, group 101 is NOP
        if (op_grp_bit == GRP_MEM[0]) begin
          case (op_sub)
            MEM_LDM: begin
              // first load cycle: address on the bus, PC held, no write-back yet
              ctrl.select_alu_arg = 1'b1;
              ctrl.alu_function   = ALU_ADD;
              ctrl.mem_read       = 1'b1;
              ctrl.enable_pc      = 1'b0;
              is_load             = 1'b1;
            end
            MEM_STM: begin
              // address Rs + imm8 through the ALU, store data read via Rd port
              ctrl.select_alu_arg = 1'b1;
              ctrl.alu_function   = ALU_ADD;
              ctrl.select_r2      = 1'b1;
              ctrl.stm            = 1'b1;
              ctrl.enable_pc      = 1'b1;
            end
            default: begin
              ctrl.enable_pc = 1'b1;
            end
          endcase
        end else begin
          ctrl.enable_pc = 1'b1;
        end
      end
      2'b11: begin
        // group 110 is shift/rotate, group 111 is NOP
        if (op_grp_bit == GRP_SHIFT[0]) begin
          ctrl.select_to_write = WB_SHIFT;
          ctrl.sh_ro_function  = op_sub;
          ctrl.enable_zero     = 1'b1;
          ctrl.enable_carry    = 1'b1;
          ctrl.enable_pc       = 1'b1;
        end else begin
          ctrl.enable_pc = 1'b1;
        end
      end
      default: begin
        // unknown opcode bits: hold the safe idle vector
        ctrl    = ctrl_idle();
        is_load = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
// Control unit of the 19-bit single-issue processor. Holds the RST/EXEC/LD2
// state register; decodes the instruction in EXEC, and overrides the decode
// in RST (everything 0) and LD2 (load write-back, independent of allBits).
// Ports:
//   clk            in  1  system clock, rising edge
//   rst            in  1  synchronous active-high reset
//   allBits        in  19 current instruction word
//   selectToWrite  out 2  write-back source (00 ALU,01 shift,10 mem,11 none)
//   selectR2       out 1  read port 2 address: 0 Rt, 1 Rd
//   selectAluArg   out 1  ALU operand B: 0 read data 2, 1 imm8
//   ALUfunction    out 3  ALU operation
//   sh_roFunction  out 2  shifter operation
//   STM            out 1  data-memory write strobe
//   LDM            out 1  load write-back strobe
//   enablePC       out 1  PC advances at next edge
//   enableZero     out 1  Z flag update
//   enableCarry    out 1  C flag update
//   memRead        out 1  data-memory read enable
// -----------------------------------------------------------------------------
module controller
  import controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] allBits,
  output logic [1:0]  selectToWrite,
  output logic        selectR2,
  output logic        selectAluArg,
  output logic [2:0]  ALUfunction,
  output logic [1:0]  sh_roFunction,
  output logic        STM,
  output logic        LDM,
  output logic        enablePC,
  output logic        enableZero,
  output logic        enableCarry,
  output logic        memRead
);

  state_t state;
  ctrl_t  dec_ctrl;
  logic   dec_is_load;
  ctrl_t  ctrl;

  // Operand fields (register numbers, imm8) never affect control.
  logic unused_operand_bits;
  assign unused_operand_bits = ^allBits[13:0];

  controller_decode u_decode (
    .opcode  (allBits[18:14]),
    .ctrl    (dec_ctrl),
    .is_load (dec_is_load)
  );

  // State register: reset wins from any state, loads take one extra cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RST;
    end else begin
      case (state)
        ST_RST:  state <= ST_EXEC;
        ST_EXEC: state <= dec_is_load ? ST_LD2 : ST_EXEC;
        ST_LD2:  state <= ST_EXEC;
        default: state <= ST_RST;
      endcase
    end
  end

  // Output select: decode in EXEC, fixed vectors in RST and LD2
  always_comb begin
    ctrl = ctrl_zero();
    case (state)
      ST_EXEC: ctrl = dec_ctrl;
      ST_LD2:  ctrl = ctrl_load2();
      ST_RST:  ctrl = ctrl_zero();
      default: ctrl = ctrl_zero();
    endcase
  end

  assign selectToWrite = ctrl.select_to_write;
  assign selectR2      = ctrl.select_r2;
  assign selectAluArg  = ctrl.select_alu_arg;
  assign ALUfunction   = ctrl.alu_function;
  assign sh_roFunction = ctrl.sh_ro_function;
  assign STM           = ctrl.stm;
  assign LDM           = ctrl.ldm;
  assign enablePC      = ctrl.enable_pc;
  assign enableZero    = ctrl.enable_zero;
  assign enableCarry   = ctrl.enable_carry;
  assign memRead       = ctrl.mem_read;

endmodule

// File: tb/tb_controller.sv
// -----------------------------------------------------------------------------
// tb_controller
// Directed-vector scoreboard bench for controller. The driver applies one
// instruction per cycle just after the rising edge and queues the
// hand-computed output vector for that cycle; the monitor compares on the
// falling edge.
// Output vector layout (15 bits):
//   {selectToWrite[1:0], selectR2, selectAluArg, ALUfunction[2:0],
//    sh_roFunction[1:0], STM, LDM, enablePC, enableZero, enableCarry, memRead}
// -----------------------------------------------------------------------------
module tb_controller;

  logic        clk;
  logic        rst;
  logic [18:0] allBits;
  logic [1:0]  selectToWrite;
  logic        selectR2;
  logic        selectAluArg;
  logic [2:0]  ALUfunction;
  logic [1:0]  sh_roFunction;
  logic        STM;
  logic        LDM;
  logic        enablePC;
  logic        enableZero;
  logic        enableCarry;
  logic        memRead;

  controller dut (
    .clk           (clk),
    .rst           (rst),
    .allBits       (allBits),
    .selectToWrite (selectToWrite),
    .selectR2      (selectR2),
    .selectAluArg  (selectAluArg),
    .ALUfunction   (ALUfunction),
    .sh_roFunction (sh_roFunction),
    .STM           (STM),
    .LDM           (LDM),
    .enablePC      (enablePC),
    .enableZero    (enableZero),
    .enableCarry   (enableCarry),
    .memRead       (memRead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [14:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  bit   driver_done = 1'b0;

  // Instruction words
  localparam logic [18:0] I_ADD    = 19'b0000010010101100000;
  localparam logic [18:0] I_MASKI  = 19'b0111111110000010000;
  localparam logic [18:0] I_ROR    = 19'b1101100110001000000;
  localparam logic [18:0] I_LDM    = 19'b1000010010100010000;
  localparam logic [18:0] I_STM    = 19'b1000110010100010000;
  localparam logic [18:0] I_SBC    = 19'b0001100000000000000;
  localparam logic [18:0] I_XOR    = 19'b0011000000000000000;
  localparam logic [18:0] I_ANDI   = 19'b0110000000000000000;
  localparam logic [18:0] I_SHL    = 19'b1100000000000000000;
  localparam logic [18:0] I_MEMNOP = 19'b1001000000000000000;
  localparam logic [18:0] I_NOP5   = 19'b1010000000000000000;
  localparam logic [18:0] I_NOP7   = 19'b1110000000000000000;

  // Build an expected vector from named fields
  function automatic logic [14:0] ev(
    input logic [1:0] stw, input logic r2, input logic arg,
    input logic [2:0] alu, input logic [1:0] sh,
    input logic stm, input logic ldm, input logic pc,
    input logic z, input logic c, input logic mr);
    return {stw, r2, arg, alu, sh, stm, ldm, pc, z, c, mr};
  endfunction

  // Hand-derived expected vectors
  logic [14:0] e_zero, e_add, e_maski, e_ror, e_ld1, e_ld2, e_stm;
  logic [14:0] e_sbc, e_xor, e_andi, e_shl, e_nop;

  initial begin
    //           stw    r2    arg   alu     sh     stm   ldm   pc    z     c     mr
    e_zero  = ev(2'b00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_add   = ev(2'b00, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_maski = ev(2'b00, 1'b0, 1'b1, 3'b111, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_ror   = ev(2'b01, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_ld1   = ev(2'b11, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    e_ld2   = ev(2'b10, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    e_stm   = ev(2'b11, 1'b1, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_sbc   = ev(2'b00, 1'b0, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_xor   = ev(2'b00, 1'b0, 1'b0, 3'b110, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_andi  = ev(2'b00, 1'b0, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    e_shl   = ev(2'b01, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    e_nop   = ev(2'b11, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  end

  // One cycle: wait for the edge, drive inputs, queue this cycle's expectation
  task automatic step(input logic r, input logic [18:0] bits,
                      input logic [14:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst     = r;
    allBits = bits;
    x.name  = nm;
    x.vec   = e;
    exp_q.push_back(x);
  endtask

  // Driver
  initial begin
    rst     = 1'b1;
    allBits = I_ADD;
    // reset held for three edges
    step(1'b1, I_ADD,    e_zero,  "rst_edge1");
    step(1'b1, I_LDM,    e_zero,  "rst_edge2");
    step(1'b1, I_STM,    e_zero,  "rst_edge3");
    // released; state still RST until the next edge
    step(1'b0, I_ADD,    e_zero,  "rst_release");
    step(1'b0, I_ADD,    e_add,   "add");
    step(1'b0, I_MASKI,  e_maski, "mask_imm");
    step(1'b0, I_ROR,    e_ror,   "ror");
    step(1'b0, I_SBC,    e_sbc,   "sbc_reg");
    step(1'b0, I_XOR,    e_xor,   "xor_reg");
    step(1'b0, I_ANDI,   e_andi,  "and_imm");
    step(1'b0, I_SHL,    e_shl,   "shl");
    step(1'b0, I_LDM,    e_ld1,   "ldm_c1");
    // LD2 ignores allBits
    step(1'b0, I_ADD,    e_ld2,   "ldm_c2");
    step(1'b0, I_STM,    e_stm,   "stm");
    step(1'b0, I_MEMNOP, e_nop,   "mem_nop");
    step(1'b0, I_NOP5,   e_nop,   "nop_101");
    step(1'b0, I_NOP7,   e_nop,   "nop_111");
    // back-to-back loads
    step(1'b0, I_LDM,    e_ld1,   "ldm2_c1");
    step(1'b0, I_LDM,    e_ld2,   "ldm2_c2");
    step(1'b0, I_LDM,    e_ld1,   "ldm3_c1");
    // reset asserted during LD2
    step(1'b1, I_LDM,    e_ld2,   "ldm3_c2_rst");
    step(1'b0, I_LDM,    e_zero,  "rst_from_ld2");
    step(1'b0, I_LDM,    e_ld1,   "ldm_after_rst");
    step(1'b0, I_ROR,    e_ld2,   "ldm_after_rst_c2");
    step(1'b0, I_ROR,    e_ror,   "ror_after_ld");
    driver_done = 1'b1;
  end

  // Monitor: compare DUT outputs on the falling edge
  initial begin
    exp_t        x;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        act = {selectToWrite, selectR2, selectAluArg, ALUfunction, sh_roFunction,
               STM, LDM, enablePC, enableZero, enableCarry, memRead};
        tests++;
        if (act !== x.vec) begin
          failed++;
          $display("FAIL %s: got %b expected %b", x.name, act, x.vec);
        end
      end
    end
  end

  // Completion with bounded waits
  initial begin
    int cyc;
    cyc = 0;
    while (!(driver_done && exp_q.size() == 0) && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    if (!(driver_done && exp_q.size() == 0)) begin
      tests++;
      failed++;
      $display("FAIL timeout: got %0d pending expected 0 pending", exp_q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
